// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address/data types and the hardwired-zero address
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF = $clog2(NREGS_DEF);
  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;
  localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with allocate-over-writeback priority
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS),
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWRITE-1:0]   wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    rd_pending
);
  logic [NREGS-1:0] pending, nxt;
  // allocate is applied after the clears: it belongs to a newer producer
  always_comb begin
    nxt = pending;
    for (int w = 0; w < NWRITE; w++)
      if (wr_en[w]) nxt[wr_addr[w*AW +: AW]] = 1'b0;
    if (alloc_en) nxt[alloc_addr] = 1'b1;
    if (ZERO_REG != 0) nxt[AW'(ZERO_ADDR)] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      rd_pending <= '0;
    end else begin
      pending <= nxt;
      for (int i = 0; i < NREAD; i++) rd_pending[i] <= nxt[rd_addr[i*AW +: AW]];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first registered reads,
// fixed write priority, optional hardwired zero register and pending scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS),
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_pending,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr
);
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] nxt [NREGS];
  // later ports overwrite earlier ones, so the highest index wins
  always_comb begin
    nxt = regs;
    for (int w = 0; w < NWRITE; w++)
      if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == AW'(ZERO_ADDR)))
        nxt[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      rd_data <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs[r] <= nxt[r];
      for (int i = 0; i < NREAD; i++) rd_data[i*XLEN +: XLEN] <= nxt[rd_addr[i*AW +: AW]];
    end
  regfile_scoreboard #(
    .NREGS(NREGS), .AW(AW), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .rd_addr(rd_addr), .rd_pending(rd_pending)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven scoreboard bench for the default regfile plus a
// second instance with two write ports and no hardwired zero
module tb_regfile_mp;
  import regfile_pkg::*;
  logic clk = 0, rst = 1;
  logic [9:0] rd_addr = '0;
  logic alloc_en = 0;
  logic [4:0] alloc_addr = '0;
  logic [0:0] wr_en_a = '0;
  logic [4:0] wr_addr_a = '0;
  logic [31:0] wr_data_a = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0] rd_pending_a, rd_pending_b;
  logic [1:0] wr_en_b = '0;
  logic [9:0] wr_addr_b = '0;
  logic [63:0] wr_data_b = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pending(rd_pending_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );
  regfile_mp #(.NWRITE(2), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pending_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  typedef struct {
    logic we; reg_addr_t wa; xlen_t wd; logic ae; reg_addr_t aa;
    reg_addr_t ra0, ra1; xlen_t e0, e1; logic [1:0] ep;
  } vec_t;
  typedef struct packed { xlen_t d0, d1; logic [1:0] p; } exp_t;
  exp_t q[$];
  vec_t tbl[12];

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic step(input vec_t v, input string n);
    exp_t e;
    @(negedge clk);
    wr_en_a = v.we; wr_addr_a = v.wa; wr_data_a = v.wd;
    alloc_en = v.ae; alloc_addr = v.aa; rd_addr = {v.ra1, v.ra0};
    q.push_back('{v.e0, v.e1, v.ep});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({n, ".d0"}, 64'(rd_data_a[31:0]), 64'(e.d0));
    check({n, ".d1"}, 64'(rd_data_a[63:32]), 64'(e.d1));
    check({n, ".pend"}, 64'(rd_pending_a), 64'(e.p));
    wr_en_a = '0; alloc_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_a.data", rd_data_a, 64'd0);
    check("reset_b.data", rd_data_b, 64'd0);
    check("reset_a.pend", 64'(rd_pending_a), 64'd0);
    @(negedge clk);
    rst = 0;
    // async reset mid-stream after a write and an allocate
    step('{1, 5, 32'hDEADBEEF, 0, 0, 5, 3, 32'hDEADBEEF, 0, 2'b00}, "pre_rst_wr");
    step('{0, 0, 0, 1, 6, 5, 6, 32'hDEADBEEF, 0, 2'b10}, "pre_rst_alloc");
    #3 rst = 1;
    #1;
    check("mid_rst.data", rd_data_a, 64'd0);
    check("mid_rst.pend", 64'(rd_pending_a), 64'd0);
    @(negedge clk);
    rst = 0;
    step('{0, 0, 0, 0, 0, 5, 6, 0, 0, 2'b00}, "post_rst_read");

    tbl[0]  = '{1, 7, 32'h12345678, 0, 0, 3, 7, 0, 32'h12345678, 2'b00};
    tbl[1]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 2'b00};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 7, 0, 32'h12345678, 2'b00};
    tbl[3]  = '{0, 0, 0, 1, 4, 4, 7, 0, 32'h12345678, 2'b01};
    tbl[4]  = '{0, 0, 0, 0, 0, 4, 4, 0, 0, 2'b11};
    tbl[5]  = '{1, 4, 32'h55, 0, 0, 4, 7, 32'h55, 32'h12345678, 2'b00};
    tbl[6]  = '{0, 0, 0, 1, 4, 7, 4, 32'h12345678, 32'h55, 2'b10};
    tbl[7]  = '{1, 4, 32'h66, 1, 4, 4, 4, 32'h66, 32'h66, 2'b11};
    tbl[8]  = '{0, 0, 0, 0, 0, 4, 4, 32'h66, 32'h66, 2'b11};
    tbl[9]  = '{1, 4, 32'h77, 0, 0, 4, 0, 32'h77, 0, 2'b00};
    tbl[10] = '{1, 30, 32'h30, 1, 31, 31, 30, 0, 32'h30, 2'b01};
    tbl[11] = '{1, 31, 32'hFFFF0001, 1, 30, 31, 30, 32'hFFFF0001, 32'h30, 2'b10};
    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

    // no hardwired zero: address 0 stores data and tracks pending
    @(negedge clk);
    wr_en_b = 2'b01; wr_addr_b = {5'd0, 5'd0}; wr_data_b = {32'h0, 32'hFFFFFFFF};
    alloc_en = 1; alloc_addr = 0; rd_addr = {5'd0, 5'd0};
    @(posedge clk);
    #1;
    check("b_zero.data", rd_data_b, {2{32'hFFFFFFFF}});
    check("b_zero.pend", 64'(rd_pending_b), 64'd3);
    // both write ports to the same address: port 1 wins, also on the bypass
    @(negedge clk);
    alloc_en = 0;
    wr_en_b = 2'b11; wr_addr_b = {5'd9, 5'd9}; wr_data_b = {32'h0000BBBB, 32'hAAAA0000};
    rd_addr = {5'd9, 5'd9};
    @(posedge clk);
    #1;
    check("b_prio.bypass", rd_data_b, {2{32'h0000BBBB}});
    check("b_prio.pend", 64'(rd_pending_b), 64'd0);
    @(negedge clk);
    wr_en_b = 2'b01; wr_addr_b = {5'd0, 5'd10}; wr_data_b = {32'h0, 32'h1010};
    rd_addr = {5'd10, 5'd9};
    @(posedge clk);
    #1;
    check("b_prio.hold", 64'(rd_data_b[31:0]), 64'h0000BBBB);
    check("b_port0.bypass", 64'(rd_data_b[63:32]), 64'h1010);
    @(negedge clk);
    wr_en_b = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read CPU register file.
- Provides NREAD registered read ports, NWRITE write ports with fixed priority, write-first bypass and an optional hardwired-zero register 0.
- Carries a per-register pending scoreboard: set on allocate, cleared on writeback.
- Sits between decode (read/allocate) and writeback in the pipeline.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; power of two, ≥2
- AW, $clog2(NREGS), address width (derived; not overridden)
- NREAD, 2, number of read ports, 1..4
- NWRITE, 1, number of write ports, 1..2
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NREAD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
- rd_pending  out  NREAD  registered pending flag of each read address
- wr_en  in  NWRITE  write enable per write port
- wr_addr  in  NWRITE*AW  write addresses
- wr_data  in  NWRITE*XLEN  write data
- alloc_en  in  1  mark alloc_addr pending (new in-flight producer)
- alloc_addr  in  AW  register to mark pending

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - all NREGS registers = 0, all pending bits = 0;
  - rd_data = 0, rd_pending = 0 immediately.
  - First sampling edge after deassert behaves normally.
  - No memory-file initialisation.
- Write:
  - At posedge, for each port w with wr_en[w]=1, regs[wr_addr[w]] <= wr_data[w].
  - Both ports to the same address: the higher port index wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read, latency 1:
  - At posedge, rd_data[i] <= value of regs[rd_addr[i]] after this edge's writes are applied (write-first bypass).
  - When several writes hit the address, the winning write is bypassed.
  - ZERO_REG=1 and address 0: rd_data[i] = 0.
  - rd_data holds until the next posedge.
- Scoreboard:
  - pending[a] is set at posedge when alloc_en=1 and alloc_addr=a.
  - pending[a] is cleared at posedge when any wr_en[w]=1 with wr_addr[w]=a.
  - Same edge, same address, alloc and write: pending stays 1 (the allocate belongs to a newer producer).
  - ZERO_REG=1: allocate to address 0 is ignored; pending[0] stays 0.
  - Allocate to an already-pending register: stays 1 (no count, single outstanding producer per register).
- rd_pending[i] <= pending[rd_addr[i]] after this edge's set/clear, consistent with rd_data write-first semantics.
- Multiple read ports on the same address return identical data and pending.
- All addresses are in range by construction (NREGS = 2^AW); no error path.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN/NREGS constants;
  - reg_addr_t typedef (AW bits) and xlen_t typedef;
  - ZERO_ADDR constant.
- One sub-module, regfile_scoreboard: owns the NREGS pending bits, the alloc/clear priority rule and the per-read-port pending lookup.
- The top level owns the data array, write priority, bypass and read registers.

Test Plan (defaults, plus NWRITE=2 where stated):
1. Reset
   - Stimulus: assert rst mid-stream after writing regs[5]=0xDEADBEEF; deassert; read addr 5 on port 0.
   - Response: rd_data=0 immediately on reset and 0 after the read edge; rd_pending=0.
2. Write-first bypass
   - Stimulus: same edge wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr port1=7.
   - Response: after that edge rd_data port1=0x12345678; port0 reading addr 3 (never written) returns 0.
3. Zero register
   - Stimulus: write 0xFFFFFFFF to addr 0, alloc_en on addr 0, read addr 0.
   - Response: rd_data=0, rd_pending=0.
   - Also with ZERO_REG=0: same sequence gives rd_data=0xFFFFFFFF.
4. Write priority (NWRITE=2)
   - Stimulus: both ports write addr 9, port0 data 0xAAAA0000, port1 data 0x0000BBBB; read addr 9.
   - Response: rd_data=0x0000BBBB on the same-edge bypass and on later reads.
5. Scoreboard lifecycle
   - Stimulus: alloc addr 4, read 4 next cycle, then write addr 4 = 0x55.
   - Response: rd_pending=1 during pending; on the write edge a read of 4 returns rd_data=0x55, rd_pending=0.
6. Alloc/clear collision
   - Stimulus: pending[4]=1; same edge alloc addr 4 and write addr 4 = 0x66; read 4 next edge.
   - Response: rd_data=0x66, rd_pending=1.
